// File: rtl/tug_war_referee.sv
// tug_war_referee: round and match controller for the tug-of-war playfield.
// Turns the raw key levels into single-cycle move pulses and cancels
// simultaneous presses. It scores a round when a player pushes off their end
// light, then holds the light chain in clear for a few cycles. The match ends
// when either score reaches WIN_SCORE.
module tug_war_referee #(
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               keyL,
    input  logic               keyR,
    input  logic               leftEnd,
    input  logic               rightEnd,
    output logic               L,
    output logic               R,
    output logic               res,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic               matchOver,
    output logic               winnerL
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               kL_q, kR_q;
    logic               L_q, L_d;
    logic               R_q, R_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] scoreL_q, scoreL_d;
    logic [SCORE_W-1:0] scoreR_q, scoreR_d;
    logic               matchOver_q, matchOver_d;
    logic               winnerL_q, winnerL_d;

    logic               eL, eR;
    logic [SCORE_W-1:0] incL, incR;

    // Register all state; key history resets high so a key held through reset is ignored.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= PLAY;
            kL_q        <= 1'b1;
            kR_q        <= 1'b1;
            L_q         <= 1'b0;
            R_q         <= 1'b0;
            cnt_q       <= '0;
            scoreL_q    <= '0;
            scoreR_q    <= '0;
            matchOver_q <= 1'b0;
            winnerL_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kL_q        <= keyL;
            kR_q        <= keyR;
            L_q         <= L_d;
            R_q         <= R_d;
            cnt_q       <= cnt_d;
            scoreL_q    <= scoreL_d;
            scoreR_q    <= scoreR_d;
            matchOver_q <= matchOver_d;
            winnerL_q   <= winnerL_d;
        end
    end

    // Edge detection, pulse generation, win scoring and round/match sequencing.
    always_comb begin
        eL          = keyL & ~kL_q;
        eR          = keyR & ~kR_q;
        incL        = scoreL_q + 1'b1;
        incR        = scoreR_q + 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        scoreL_d    = scoreL_q;
        scoreR_d    = scoreR_q;
        matchOver_d = matchOver_q;
        winnerL_d   = winnerL_q;
        L_d         = eL & ~eR & (state_q == PLAY);
        R_d         = eR & ~eL & (state_q == PLAY);

        case (state_q)
            PLAY: begin
                // The final win also squashes any pulse raised on that edge, so the
                // playfield is already frozen in the first DONE cycle.
                if (L_q && leftEnd) begin
                    scoreL_d = incL;
                    if (incL == WIN_VAL) begin
                        state_d     = DONE;
                        matchOver_d = 1'b1;
                        winnerL_d   = 1'b1;
                        L_d         = 1'b0;
                        R_d         = 1'b0;
                    end else begin
                        state_d = CLEAR;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (R_q && rightEnd) begin
                    scoreR_d = incR;
                    if (incR == WIN_VAL) begin
                        state_d     = DONE;
                        matchOver_d = 1'b1;
                        winnerL_d   = 1'b0;
                        L_d         = 1'b0;
                        R_d         = 1'b0;
                    end else begin
                        state_d = CLEAR;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = PLAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    assign L         = L_q;
    assign R         = R_q;
    assign res       = (state_q == CLEAR);
    assign scoreL    = scoreL_q;
    assign scoreR    = scoreR_q;
    assign matchOver = matchOver_q;
    assign winnerL   = winnerL_q;

endmodule

// File: tb/tb_tug_war_referee.sv
// tb_tug_war_referee: drives two referees (default parameters and the minimal
// 1-bit / one-win / one-hold-cycle configuration) from the same keys and end
// lights, and compares every output against a round-level reference model.
module tb_tug_war_referee;

    logic       Clock;
    logic       Reset;
    logic       keyL, keyR, leftEnd, rightEnd;

    logic       L0, R0, res0, matchOver0, winnerL0;
    logic [2:0] scoreL0, scoreR0;
    logic       L1, R1, res1, matchOver1, winnerL1;
    logic [0:0] scoreL1, scoreR1;

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, the outstanding clear cycles, scores and
    // the last key levels; index 0 = default config, index 1 = minimal config.
    int holdC[2] = '{4, 1};
    int winS[2]  = '{7, 1};
    int clearLeft[2];
    int sL[2];
    int sR[2];
    bit over[2];
    bit winL[2];
    bit pL[2];
    bit pR[2];
    bit prevL[2];
    bit prevR[2];

    int resCount;
    int smallResSeen;

    tug_war_referee dut (
        .Clock(Clock), .Reset(Reset), .keyL(keyL), .keyR(keyR),
        .leftEnd(leftEnd), .rightEnd(rightEnd), .L(L0), .R(R0), .res(res0),
        .scoreL(scoreL0), .scoreR(scoreR0), .matchOver(matchOver0), .winnerL(winnerL0)
    );

    tug_war_referee #(.SCORE_W(1), .WIN_SCORE(1), .HOLD_CYCLES(1)) dutSmall (
        .Clock(Clock), .Reset(Reset), .keyL(keyL), .keyR(keyR),
        .leftEnd(leftEnd), .rightEnd(rightEnd), .L(L1), .R(R1), .res(res1),
        .scoreL(scoreL1), .scoreR(scoreR1), .matchOver(matchOver1), .winnerL(winnerL1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            clearLeft[i] = 0;
            sL[i] = 0;
            sR[i] = 0;
            over[i] = 1'b0;
            winL[i] = 1'b0;
            pL[i] = 1'b0;
            pR[i] = 1'b0;
            prevL[i] = 1'b1;
            prevR[i] = 1'b1;
        end
    endtask

    // One clock edge of the referee rules: a pulse from the previous cycle that
    // lands on an end light wins the round, unless a clear is still running.
    task automatic modelStep();
        bit eL, eR, inPlay, nL, nR;
        if (Reset) begin
            modelReset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            eL = keyL && !prevL[i];
            eR = keyR && !prevR[i];
            inPlay = (clearLeft[i] == 0) && !over[i];
            nL = eL && !eR && inPlay;
            nR = eR && !eL && inPlay;
            if (inPlay && pL[i] && leftEnd) begin
                sL[i]++;
                if (sL[i] == winS[i]) begin
                    over[i] = 1'b1;
                    winL[i] = 1'b1;
                    nL = 1'b0;
                    nR = 1'b0;
                end else begin
                    clearLeft[i] = holdC[i];
                end
            end else if (inPlay && pR[i] && rightEnd) begin
                sR[i]++;
                if (sR[i] == winS[i]) begin
                    over[i] = 1'b1;
                    winL[i] = 1'b0;
                    nL = 1'b0;
                    nR = 1'b0;
                end else begin
                    clearLeft[i] = holdC[i];
                end
            end else if (clearLeft[i] > 0) begin
                clearLeft[i]--;
            end
            prevL[i] = keyL;
            prevR[i] = keyR;
            pL[i] = nL;
            pR[i] = nR;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("L0", 8'(L0), 8'(pL[0]));
        checkOutput("R0", 8'(R0), 8'(pR[0]));
        checkOutput("res0", 8'(res0), 8'(clearLeft[0] > 0));
        checkOutput("scoreL0", 8'(scoreL0), 8'(sL[0]));
        checkOutput("scoreR0", 8'(scoreR0), 8'(sR[0]));
        checkOutput("matchOver0", 8'(matchOver0), 8'(over[0]));
        checkOutput("winnerL0", 8'(winnerL0), 8'(winL[0]));
        checkOutput("L1", 8'(L1), 8'(pL[1]));
        checkOutput("R1", 8'(R1), 8'(pR[1]));
        checkOutput("res1", 8'(res1), 8'(clearLeft[1] > 0));
        checkOutput("scoreL1", 8'(scoreL1), 8'(sL[1]));
        checkOutput("scoreR1", 8'(scoreR1), 8'(sR[1]));
        checkOutput("matchOver1", 8'(matchOver1), 8'(over[1]));
        checkOutput("winnerL1", 8'(winnerL1), 8'(winL[1]));
    endtask

    task automatic applyStimulus(input bit kl, input bit kr, input bit le, input bit re);
        keyL = kl;
        keyR = kr;
        leftEnd = le;
        rightEnd = re;
    endtask

    // Advance one edge, step the model with the inputs that edge saw, then compare.
    task automatic tick();
        @(posedge Clock);
        modelStep();
        #1;
        if (res1) smallResSeen++;
        checkAll();
    endtask

    // Raise Reset between edges and compare before any clock edge arrives.
    task automatic asyncReset();
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        smallResSeen = 0;
        applyStimulus(1, 0, 0, 0);
        modelReset();
        tick();
        tick();
        Reset = 1'b0;

        // Key held through reset must not pulse; release then press pulses once.
        repeat (3) tick();
        checkOutput("heldThroughReset", 8'(L0), 8'd0);
        applyStimulus(0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("pressPulse", 8'(L0), 8'd1);
        tick();
        checkOutput("singlePulse", 8'(L0), 8'd0);

        // Simultaneous rising edges cancel.
        applyStimulus(0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 0);
        tick();
        checkOutput("simulL", 8'(L0), 8'd0);
        checkOutput("simulR", 8'(R0), 8'd0);
        tick();
        checkOutput("simulScore", 8'(scoreL0 + scoreR0), 8'd0);
        applyStimulus(0, 0, 0, 0);
        tick();

        // Left round win: score, 4-cycle clear, presses during clear ignored.
        applyStimulus(1, 0, 1, 0);
        tick();
        tick();
        checkOutput("winScoreL", 8'(scoreL0), 8'd1);
        checkOutput("winRes", 8'(res0), 8'd1);
        checkOutput("smallOver", 8'(matchOver1), 8'd1);
        checkOutput("smallWinnerL", 8'(winnerL1), 8'd1);
        checkOutput("smallScoreL", 8'(scoreL1), 8'd1);
        resCount = 1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(bit'(i % 2), 0, 0, 0);
            tick();
            if (res0) resCount++;
        end
        checkOutput("resLength", 8'(resCount), 8'd4);
        checkOutput("smallNoRes", 8'(smallResSeen), 8'd0);
        applyStimulus(0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("pressAfterClear", 8'(L0), 8'd1);

        // Randomized play with random end lights, in two stretches.
        for (int blk = 0; blk < 2; blk++) begin
            asyncReset();
            for (int i = 0; i < 250; i++) begin
                applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
                tick();
            end
        end

        // Right player takes all seven rounds.
        asyncReset();
        applyStimulus(0, 0, 0, 1);
        tick();
        for (int r = 0; r < 7; r++) begin
            applyStimulus(0, 1, 0, 1);
            tick();
            applyStimulus(0, 0, 0, 1);
            repeat (5) tick();
        end
        checkOutput("rightScore7", 8'(scoreR0), 8'd7);
        checkOutput("rightOver", 8'(matchOver0), 8'd1);
        checkOutput("rightWinner", 8'(winnerL0), 8'd0);
        checkOutput("doneNoRes", 8'(res0), 8'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bit'(i % 2), bit'(i % 2), 1, 1);
            tick();
            checkOutput("doneNoPulse", 8'({L0, R0}), 8'd0);
        end
        checkOutput("doneScoreHeld", 8'(scoreR0), 8'd7);

        // Async reset in the middle of a clear with scoreL at 3.
        asyncReset();
        applyStimulus(0, 0, 1, 0);
        tick();
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1, 0, 1, 0);
            tick();
            applyStimulus(0, 0, 1, 0);
            repeat (5) tick();
        end
        applyStimulus(1, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        tick();
        tick();
        checkOutput("midClearScore", 8'(scoreL0), 8'd3);
        checkOutput("midClearRes", 8'(res0), 8'd1);
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncScoreL", 8'(scoreL0), 8'd0);
        checkOutput("asyncRes", 8'(res0), 8'd0);
        checkAll();
        tick();
        Reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("pressAfterReset", 8'(L0), 8'd1);
        applyStimulus(0, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
